// File: rtl/rocket_mmio_responder.sv
// MMIO device block behind the Rocket memory-style port: stop/exit register,
// putchar FIFO with a valid/ready drain port, and a 64-bit mtime/mtimecmp timer.
module rocket_mmio_responder #(
  parameter int MMIO_ADDR_WIDTH = 31,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clock,
  input  logic                       reset_wire_reset,
  input  logic                       mmio_req_i,
  input  logic                       mmio_we_i,
  input  logic [MMIO_ADDR_WIDTH-1:0] mmio_addr_i,
  input  logic [DATA_WIDTH/8-1:0]    mmio_strb_i,
  input  logic [DATA_WIDTH-1:0]      mmio_wdata_i,
  output logic [DATA_WIDTH-1:0]      mmio_rdata_o,
  output logic                       char_valid_o,
  output logic [7:0]                 char_data_o,
  input  logic                       char_ready_i,
  output logic                       stop_o,
  output logic [31:0]                stop_code_o,
  output logic                       putc_overflow_o,
  output logic                       timer_irq_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [8:0] IDX_STOP     = 9'h000;
  localparam logic [8:0] IDX_PUTC     = 9'h001;
  localparam logic [8:0] IDX_MTIME    = 9'h002;
  localparam logic [8:0] IDX_MTIMECMP = 9'h003;

  // Handshake: the drain port pops the FIFO head on any cycle where
  // char_valid_o and char_ready_i are both high; char_data_o is stable while
  // char_valid_o is high and no pop has happened.

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_stop;
  logic [31:0]           r_stop_code;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_mtime;
  logic [DATA_WIDTH-1:0] r_mtimecmp;
  logic                  r_irq;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [8:0]            w_idx;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_putc_wr;
  logic                  w_push;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic [DATA_WIDTH-1:0] w_mtime_merge;
  logic [DATA_WIDTH-1:0] w_cmp_merge;
  logic                  w_unused;

  assign w_idx     = mmio_addr_i[11:3];
  assign w_rd      = mmio_req_i & ~mmio_we_i;
  assign w_wr      = mmio_req_i & mmio_we_i;
  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = w_valid & char_ready_i;
  assign w_putc_wr = w_wr & (w_idx == IDX_PUTC) & mmio_strb_i[0];
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign w_push    = w_putc_wr & (~w_full | w_pop);
  assign w_drop    = w_putc_wr & w_full & ~w_pop;
  assign w_unused  = ^{mmio_addr_i[MMIO_ADDR_WIDTH-1:12], mmio_addr_i[2:0]};

  always_comb begin
    w_mtime_merge = r_mtime;
    w_cmp_merge   = r_mtimecmp;
    for (int b = 0; b < NB; b++) begin
      if (mmio_strb_i[b]) begin
        w_mtime_merge[b*8 +: 8] = mmio_wdata_i[b*8 +: 8];
        w_cmp_merge[b*8 +: 8]   = mmio_wdata_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      IDX_STOP: begin
        w_rd_val[0]    = r_stop;
        w_rd_val[32:1] = r_stop_code;
      end
      IDX_PUTC: begin
        w_rd_val[DATA_WIDTH-1] = r_ovf;
        w_rd_val[CW-1:0]       = r_count;
      end
      IDX_MTIME:    w_rd_val = r_mtime;
      IDX_MTIMECMP: w_rd_val = r_mtimecmp;
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_wire_reset) begin
      r_rdata     <= '0;
      r_stop      <= 1'b0;
      r_stop_code <= '0;
      r_ovf       <= 1'b0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_irq       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_rd) r_rdata <= w_rd_val;

      if (w_wr && (w_idx == IDX_STOP) && mmio_strb_i[0] && !r_stop) begin
        r_stop      <= 1'b1;
        r_stop_code <= mmio_wdata_i[31:0];
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= mmio_wdata_i[7:0];
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_ovf <= 1'b1;

      // A write to mtime takes the place of that cycle's increment.
      if (w_wr && (w_idx == IDX_MTIME)) r_mtime <= w_mtime_merge;
      else                              r_mtime <= r_mtime + 1'b1;
      if (w_wr && (w_idx == IDX_MTIMECMP)) r_mtimecmp <= w_cmp_merge;

      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign mmio_rdata_o    = r_rdata;
  assign char_valid_o    = w_valid;
  assign char_data_o     = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign stop_o          = r_stop;
  assign stop_code_o     = r_stop_code;
  assign putc_overflow_o = r_ovf;
  assign timer_irq_o     = r_irq;

endmodule
